dmem_ctrl: RTL and testbench

//  Parametrised RV32 data-memory controller: valid/ready request port, 1-cycle response, internal byte-enabled sync RAM.

---
 rtl/dmem_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// RV32 data-memory controller with byte-enabled sync RAM.
// Word-crossing accesses are split into two RAM beats.
module dmem_ctrl #(
    parameter int DEPTH_LOG2  = 13,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        sclk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t state_q, state_d;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_q;
    logic [31:0] hold_q;

    logic                  ram_en;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wd;

    logic                  accept;
    logic [1:0]            off;
    logic [2:0]            n3;
    logic [3:0]            mask4;
    logic [7:0]            be64;
    logic [63:0]           wd64;
    logic                  crossing;
    logic                  op_bad;
    logic                  err;
    logic                  go_split;
    logic [DEPTH_LOG2-1:0] w0;
    logic [DEPTH_LOG2-1:0] w1;

    logic                  rsp_valid_q;
    logic                  err_q;
    logic                  wr_q;
    logic [2:0]            op_q;
    logic [1:0]            off_q;
    logic                  split_q;
    logic [DEPTH_LOG2-1:0] addr_b_q;
    logic [3:0]            be_b_q;
    logic [31:0]           wd_b_q;

    logic [63:0]           pair;
    logic [63:0]           sh;
    logic [31:0]           ext;
    logic                  unused_bits;

    assign accept = req_valid & req_ready;
    assign off    = req_addr[1:0];
    assign w0     = req_addr[DEPTH_LOG2+1:2];
    assign w1     = w0 + DEPTH_LOG2'(1);

    always_comb begin
        n3    = 3'd4;
        mask4 = 4'b1111;
        case (req_op[1:0])
            2'b00: begin
                n3    = 3'd1;
                mask4 = 4'b0001;
            end
            2'b01: begin
                n3    = 3'd2;
                mask4 = 4'b0011;
            end
            default: begin
                n3    = 3'd4;
                mask4 = 4'b1111;
            end
        endcase
    end

    assign crossing = ({1'b0, off} + n3) > 3'd4;
    assign be64     = {4'b0, mask4} << off;
    assign wd64     = {32'b0, req_wdata} << {off, 3'b000};

    always_comb begin
        if (req_wr) begin
            op_bad = !(req_op == 3'b000 || req_op == 3'b001 ||
                       req_op == 3'b010);
        end else begin
            op_bad = (req_op == 3'b011) || (req_op == 3'b110) ||
                     (req_op == 3'b111);
        end
    end

    assign err      = op_bad | (crossing & !MISALIGN_EN);
    assign go_split = crossing & !op_bad & MISALIGN_EN;

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = (state_q != SPLIT);
        ram_en    = 1'b0;
        ram_addr  = w0;
        ram_be    = 4'b0;
        ram_wd    = wd64[31:0];
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ram_en = 1'b1;
                    if (req_wr && !err) begin
                        ram_be = be64[3:0];
                    end
                    if (go_split) begin
                        state_d = SPLIT;
                    end
                end
            end
            SPLIT: begin
                ram_en   = 1'b1;
                ram_addr = addr_b_q;
                ram_be   = wr_q ? be_b_q : 4'b0;
                ram_wd   = wd_b_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Single-port RAM: read-first, contents deliberately not reset
    always_ff @(posedge sclk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    mem[ram_addr][8*i +: 8] <= ram_wd[8*i +: 8];
                end
            end
            rd_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wr_q        <= 1'b0;
            op_q        <= 3'b0;
            off_q       <= 2'b0;
            split_q     <= 1'b0;
            addr_b_q    <= '0;
            be_b_q      <= 4'b0;
            wd_b_q      <= 32'b0;
            hold_q      <= 32'b0;
        end else begin
            rsp_valid_q <= (accept & !go_split) | (state_q == SPLIT);
            if (accept) begin
                err_q    <= err;
                wr_q     <= req_wr;
                op_q     <= req_op;
                off_q    <= off;
                split_q  <= go_split;
                addr_b_q <= w1;
                be_b_q   <= be64[7:4];
                wd_b_q   <= wd64[63:32];
            end
            if (state_q == SPLIT) begin
                hold_q <= rd_q;
            end
        end
    end

    assign pair = split_q ? {rd_q, hold_q} : {32'b0, rd_q};
    assign sh   = pair >> {off_q, 3'b000};

    always_comb begin
        ext = 32'b0;
        case (op_q)
            3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
            3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
            3'b010:  ext = sh[31:0];
            3'b100:  ext = {24'b0, sh[7:0]};
            3'b101:  ext = {16'b0, sh[15:0]};
            default: ext = 32'b0;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_valid_q & err_q;
    assign rsp_rdata = (rsp_valid_q && !err_q && !wr_q) ? ext : 32'b0;

    assign unused_bits = ^{sh[63:32], req_addr[31:DEPTH_LOG2+2]};

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: split and misaligned accesses,
// error responses, address wrap and reset mid-split.
module tb_dmem_ctrl;

    logic        sclk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_wr;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        req_ready0, rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 sclk = ~sclk;

    dmem_ctrl #(.DEPTH_LOG2(13), .MISALIGN_EN(1'b1)) u_dut (
        .sclk      (sclk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_ctrl #(.DEPTH_LOG2(13), .MISALIGN_EN(1'b0)) u_dut0 (
        .sclk      (sclk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready0),
        .req_wr    (req_wr),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request; returns #1 after the accepting edge
    task automatic req(input logic wr, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_wr    = wr;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge sclk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle1();
        @(posedge sclk);
        #1;
    endtask

    initial begin
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_op    = 3'b0;
        req_addr  = 32'b0;
        req_wdata = 32'b0;
        #12;
        chk("rst ready", {31'b0, req_ready}, 32'd1);
        chk("rst valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst err", {31'b0, rsp_err}, 32'd0);
        chk("rst rdata", rsp_rdata, 32'd0);
        rstn = 1'b1;
        idle1();

        // aligned word store then load, back-to-back
        req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        chk("sw valid", {31'b0, rsp_valid}, 32'd1);
        chk("sw err", {31'b0, rsp_err}, 32'd0);
        chk("sw rdata", rsp_rdata, 32'd0);
        chk("sw ready", {31'b0, req_ready}, 32'd1);
        req(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw valid", {31'b0, rsp_valid}, 32'd1);
        chk("lw rdata", rsp_rdata, 32'hDEADBEEF);
        chk("lw err", {31'b0, rsp_err}, 32'd0);
        idle1();
        chk("idle valid", {31'b0, rsp_valid}, 32'd0);
        chk("idle rdata", rsp_rdata, 32'd0);

        // byte store and signed/unsigned byte loads
        req(1'b1, 3'b000, 32'h101, 32'h80);
        req(1'b0, 3'b000, 32'h101, 32'h0);
        chk("lb 101", rsp_rdata, 32'hFFFFFF80);
        req(1'b0, 3'b100, 32'h101, 32'h0);
        chk("lbu 101", rsp_rdata, 32'h00000080);
        req(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw 100 after sb", rsp_rdata, 32'hDEAD80EF);

        // crossing word store
        req(1'b1, 3'b010, 32'h200, 32'hAABBCCDD);
        req(1'b1, 3'b010, 32'h204, 32'h55667788);
        req(1'b1, 3'b010, 32'h203, 32'h11223344);
        chk("sw203 ready", {31'b0, req_ready}, 32'd0);
        chk("sw203 valid+1", {31'b0, rsp_valid}, 32'd0);
        idle1();
        chk("sw203 valid+2", {31'b0, rsp_valid}, 32'd1);
        chk("sw203 err", {31'b0, rsp_err}, 32'd0);
        chk("sw203 ready+2", {31'b0, req_ready}, 32'd1);
        req(1'b0, 3'b010, 32'h200, 32'h0);
        chk("lw 200", rsp_rdata, 32'h44BBCCDD);
        req(1'b0, 3'b010, 32'h204, 32'h0);
        chk("lw 204", rsp_rdata, 32'h55112233);

        // crossing and non-crossing halfword loads
        req(1'b1, 3'b000, 32'h103, 32'h34);
        req(1'b1, 3'b000, 32'h104, 32'h92);
        req(1'b0, 3'b001, 32'h103, 32'h0);
        chk("lh103 ready", {31'b0, req_ready}, 32'd0);
        idle1();
        chk("lh103 valid", {31'b0, rsp_valid}, 32'd1);
        chk("lh 103", rsp_rdata, 32'hFFFF9234);
        req(1'b0, 3'b101, 32'h103, 32'h0);
        idle1();
        chk("lhu 103", rsp_rdata, 32'h00009234);
        req(1'b0, 3'b001, 32'h101, 32'h0);
        chk("lh101 valid", {31'b0, rsp_valid}, 32'd1);
        chk("lh 101", rsp_rdata, 32'hFFFFAD80);

        // top word wraps to word 0; upper address bits alias
        req(1'b1, 3'b010, 32'h7FFC, 32'h01020304);
        req(1'b1, 3'b010, 32'h0, 32'hA0B0C0D0);
        req(1'b0, 3'b010, 32'h7FFE, 32'h0);
        idle1();
        chk("lw wrap", rsp_rdata, 32'hC0D00102);
        req(1'b0, 3'b010, 32'hFFFC, 32'h0);
        chk("lw alias", rsp_rdata, 32'h01020304);

        // invalid ops
        req(1'b1, 3'b011, 32'h100, 32'hFFFFFFFF);
        chk("bad st valid", {31'b0, rsp_valid}, 32'd1);
        chk("bad st err", {31'b0, rsp_err}, 32'd1);
        chk("bad st rdata", rsp_rdata, 32'd0);
        req(1'b0, 3'b010, 32'h100, 32'h0);
        chk("no write err", {31'b0, rsp_err}, 32'd0);
        chk("no write data", rsp_rdata, 32'h34AD80EF);
        req(1'b0, 3'b110, 32'h100, 32'h0);
        chk("bad ld err", {31'b0, rsp_err}, 32'd1);
        chk("bad ld rdata", rsp_rdata, 32'd0);

        // MISALIGN_EN=0 instance flags crossings
        req(1'b0, 3'b010, 32'h1, 32'h0);
        chk("m0 lw1 valid", {31'b0, rsp_valid0}, 32'd1);
        chk("m0 lw1 err", {31'b0, rsp_err0}, 32'd1);
        chk("m0 lw1 rdata", rsp_rdata0, 32'd0);
        idle1();
        req(1'b1, 3'b010, 32'h202, 32'hFFFFFFFF);
        chk("m0 sw202 err", {31'b0, rsp_err0}, 32'd1);
        idle1();
        req(1'b0, 3'b010, 32'h200, 32'h0);
        chk("m0 lw200 err", {31'b0, rsp_err0}, 32'd0);
        chk("m0 lw200", rsp_rdata0, 32'hAABBCCDD);

        // reset while in SPLIT
        req(1'b1, 3'b010, 32'h304, 32'h12345678);
        req(1'b1, 3'b010, 32'h302, 32'hCAFEF00D);
        chk("split ready", {31'b0, req_ready}, 32'd0);
        rstn = 1'b0;
        #1;
        chk("rst split ready", {31'b0, req_ready}, 32'd1);
        chk("rst split valid", {31'b0, rsp_valid}, 32'd0);
        idle1();
        chk("rst held valid", {31'b0, rsp_valid}, 32'd0);
        #3;
        rstn = 1'b1;
        idle1();
        chk("post rst valid", {31'b0, rsp_valid}, 32'd0);
        req(1'b0, 3'b010, 32'h304, 32'h0);
        chk("w+1 intact", rsp_rdata, 32'h12345678);
        req(1'b0, 3'b101, 32'h302, 32'h0);
        chk("beat A bytes", rsp_rdata, 32'h0000F00D);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
